// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encodings, word geometry
// and a byte-lane selector.
package dmem_arbiter_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W          = 2;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [CNT_W-1:0] idx);
        logic [31:0] s;
        s = w >> {idx, 3'b000};
        return s[7:0];
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-request round-robin grant; the pointer moves only when the FSM accepts.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic       gnt_o,
    output logic       any_o
);

    logic last_q, last_d;

    // On a tie the port that did not win last time goes first.
    always_comb begin
        gnt_o = (req_i == 2'b11) ? ~last_q : req_i[1];
        any_o = |req_i;
        last_d = accept_i ? gnt_o : last_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) last_q <= 1'b1;
        else       last_q <= last_d;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port word arbiter for the byte-wide data memory: each granted word access
// becomes four little-endian byte cycles, with a CPU stall while port 0 waits.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [31:0]       addr0_i,
    input  logic [31:0]       wdata0_i,
    output logic              ack0_o,
    output logic [31:0]       rdata0_o,
    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [31:0]       addr1_i,
    input  logic [31:0]       wdata1_i,
    output logic              ack1_o,
    output logic [31:0]       rdata1_o,
    output logic              stall_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    input  logic [7:0]        mem_rdata_i
);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_nxt;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [23:0]       res_q, res_d;
    logic [31:0]       rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d, mem_re_q, mem_re_d;

    logic              gnt, any_req, accept;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic              unused_addr_hi;

    assign unused_addr_hi = ^{addr0_i[31:ADDR_W], addr1_i[31:ADDR_W]};

    rr_arbiter2 u_rr (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    ({req1_i, req0_i}),
        .accept_i (accept),
        .gnt_o    (gnt),
        .any_o    (any_req)
    );

    assign sel_we    = gnt ? we1_i : we0_i;
    assign sel_addr  = gnt ? addr1_i[ADDR_W-1:0] : addr0_i[ADDR_W-1:0];
    assign sel_wdata = gnt ? wdata1_i : wdata0_i;
    assign cnt_nxt   = cnt_q + 1'b1;

    // Memory-side outputs are registered one byte ahead so that the address,
    // data and strobes line up with cnt during each XFER cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        port_d      = port_q;
        we_d        = we_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        res_d       = res_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = mem_we_q;
        mem_re_d    = mem_re_q;
        accept      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    accept      = 1'b1;
                    port_d      = gnt;
                    we_d        = sel_we;
                    base_d      = sel_addr;
                    wdata_d     = sel_wdata;
                    cnt_d       = '0;
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata[7:0];
                    mem_we_d    = sel_we;
                    mem_re_d    = ~sel_we;
                    state_d     = ST_XFER;
                end
            end
            ST_XFER: begin
                if (!we_q) begin
                    case (cnt_q)
                        2'd0:    res_d[7:0]   = mem_rdata_i;
                        2'd1:    res_d[15:8]  = mem_rdata_i;
                        2'd2:    res_d[23:16] = mem_rdata_i;
                        default: ;
                    endcase
                end
                if (cnt_q == LAST_BYTE) begin
                    state_d  = ST_DONE;
                    mem_we_d = 1'b0;
                    mem_re_d = 1'b0;
                    // The top byte arrives this cycle, so the word is visible in DONE.
                    if (!we_q) begin
                        if (port_q) rdata1_d = {mem_rdata_i, res_q};
                        else        rdata0_d = {mem_rdata_i, res_q};
                    end
                end else begin
                    cnt_d       = cnt_nxt;
                    mem_addr_d  = base_q + ADDR_W'(cnt_nxt);
                    mem_wdata_d = byte_of(wdata_q, cnt_nxt);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            base_q      <= '0;
            wdata_q     <= '0;
            res_q       <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            port_q      <= port_d;
            we_q        <= we_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            res_q       <= res_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
        end
    end

    assign ack0_o      = (state_q == ST_DONE) & ~port_q;
    assign ack1_o      = (state_q == ST_DONE) &  port_q;
    assign rdata0_o    = rdata0_q;
    assign rdata1_o    = rdata1_q;
    assign stall_o     = req0_i & ~ack0_o;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_we_o    = mem_we_q;
    assign mem_re_o    = mem_re_q;

endmodule
